// File: rtl/overlay_blit_subsystem.sv
// overlay_blit_subsystem
//
// Copies one of NUM_MSG message sprites from an external sprite ROM into the
// frame buffer. The sprite is placed at a runtime origin, integer-scaled by
// SCALE on both axes and clipped to SCREEN_W x SCREEN_H. The write side
// honours back-pressure from the engine pixel-write MUX. Dropping RUN_OVERLAY
// mid-copy aborts without raising OVERLAY_DONE.
//
// Optional feature: define OVERLAY_TRANSPARENCY_EN to skip held pixels equal
// to KEY_COLOR. They are treated like clipped pixels.
//
// Ports
//   CLOCK_50      in   master clock
//   RESET_H       in   synchronous active-high reset
//   RUN_OVERLAY   in   level request from the system FSM
//   MSG_SEL       in   sprite select, latched at start
//   ORIGIN_X/Y    in   top-left screen position, latched at start
//   WR_READY      in   write MUX accepts the presented pixel
//   ROM_RE        out  ROM read enable
//   ROM_ID        out  ROM sprite id
//   ROM_X/ROM_Y   out  source coordinates
//   ROM_PIXEL     in   ROM data, valid one cycle after ROM_RE
//   WE            out  pixel write strobe
//   PIXEL_DOUT    out  pixel colour
//   PIXEL_X/Y     out  pixel destination
//   BUSY          out  high whenever not idle
//   OVERLAY_DONE  out  completion flag, held while RUN_OVERLAY stays high
module overlay_blit_subsystem #(
    parameter int         SPR_W     = 64,
    parameter int         SPR_H     = 32,
    parameter int         NUM_MSG   = 4,
    parameter int         SCALE     = 2,
    parameter int         SCREEN_W  = 320,
    parameter int         SCREEN_H  = 240,
    parameter logic [7:0] KEY_COLOR = 8'hE3
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_H,
    input  logic                       RUN_OVERLAY,
    input  logic [$clog2(NUM_MSG)-1:0] MSG_SEL,
    input  logic [8:0]                 ORIGIN_X,
    input  logic [8:0]                 ORIGIN_Y,
    input  logic                       WR_READY,
    output logic                       ROM_RE,
    output logic [$clog2(NUM_MSG)-1:0] ROM_ID,
    output logic [$clog2(SPR_W)-1:0]   ROM_X,
    output logic [$clog2(SPR_H)-1:0]   ROM_Y,
    input  logic [7:0]                 ROM_PIXEL,
    output logic                       WE,
    output logic [7:0]                 PIXEL_DOUT,
    output logic [8:0]                 PIXEL_X,
    output logic [8:0]                 PIXEL_Y,
    output logic                       BUSY,
    output logic                       OVERLAY_DONE
);

    localparam int MW = $clog2(NUM_MSG);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam int DW = (SCALE > 1) ? $clog2(SCALE) : 1;

`ifdef OVERLAY_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t        state;
    logic [MW-1:0] msg_id;
    logic [8:0]    org_x;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic [DW-1:0] dx, dy;
    // base_* is the top-left of the current SCALE x SCALE block, cur_* the
    // pixel being presented. 10 bits so off-screen positions never wrap.
    logic [9:0]    base_x, base_y, cur_x, cur_y;
    logic [9:0]    nxt_x, nxt_y;
    logic          last_dx, last_dy, last_sx, last_sy, advance;

    // A pixel is emitted only if on screen and, with transparency, not keyed.
    function automatic logic visible(input logic [9:0] x, input logic [9:0] y,
                                     input logic [7:0] pix);
        return (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H)) &&
               !(TRANSP_EN && (pix == KEY_COLOR));
    endfunction

    assign ROM_ID  = msg_id;
    assign ROM_X   = sx;
    assign ROM_Y   = sy;

    assign last_dx = (dx == DW'(SCALE - 1));
    assign last_dy = (dy == DW'(SCALE - 1));
    assign last_sx = (sx == XW'(SPR_W - 1));
    assign last_sy = (sy == YW'(SPR_H - 1));
    // WE low means the current sub-pixel is clipped/keyed: move on at once.
    assign advance = !WE || WR_READY;

    // Next sub-pixel inside the block: dx inner, dy outer.
    always_comb begin
        nxt_x = cur_x + 10'd1;
        nxt_y = cur_y;
        if (last_dx) begin
            nxt_x = base_x;
            nxt_y = cur_y + 10'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET_H) begin
            state        <= S_IDLE;
            msg_id       <= '0;
            org_x        <= '0;
            sx           <= '0;
            sy           <= '0;
            dx           <= '0;
            dy           <= '0;
            base_x       <= '0;
            base_y       <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            ROM_RE       <= 1'b0;
            WE           <= 1'b0;
            PIXEL_DOUT   <= '0;
            PIXEL_X      <= '0;
            PIXEL_Y      <= '0;
            BUSY         <= 1'b0;
            OVERLAY_DONE <= 1'b0;
        end else if (!RUN_OVERLAY &&
                     (state == S_FETCH || state == S_WAIT || state == S_WRITE)) begin
            // Abort: any pending unaccepted write is simply dropped.
            state  <= S_IDLE;
            ROM_RE <= 1'b0;
            WE     <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (RUN_OVERLAY) begin
                        msg_id <= MSG_SEL;
                        org_x  <= ORIGIN_X;
                        base_x <= {1'b0, ORIGIN_X};
                        base_y <= {1'b0, ORIGIN_Y};
                        sx     <= '0;
                        sy     <= '0;
                        dx     <= '0;
                        dy     <= '0;
                        ROM_RE <= 1'b1;
                        BUSY   <= 1'b1;
                        state  <= S_FETCH;
                    end
                end
                // ROM address presented; data returns next cycle.
                S_FETCH: begin
                    ROM_RE <= 1'b0;
                    state  <= S_WAIT;
                end
                // ROM data captured; first sub-pixel of the block set up.
                S_WAIT: begin
                    PIXEL_DOUT <= ROM_PIXEL;
                    cur_x      <= base_x;
                    cur_y      <= base_y;
                    PIXEL_X    <= base_x[8:0];
                    PIXEL_Y    <= base_y[8:0];
                    WE         <= visible(base_x, base_y, ROM_PIXEL);
                    state      <= S_WRITE;
                end
                // One sub-pixel per accepted (or skipped) cycle.
                S_WRITE: begin
                    if (advance) begin
                        if (!(last_dx && last_dy)) begin
                            dx      <= last_dx ? '0 : dx + DW'(1);
                            if (last_dx) dy <= dy + DW'(1);
                            cur_x   <= nxt_x;
                            cur_y   <= nxt_y;
                            PIXEL_X <= nxt_x[8:0];
                            PIXEL_Y <= nxt_y[8:0];
                            WE      <= visible(nxt_x, nxt_y, PIXEL_DOUT);
                        end else begin
                            dx <= '0;
                            dy <= '0;
                            WE <= 1'b0;
                            if (last_sx) begin
                                sx     <= '0;
                                base_x <= {1'b0, org_x};
                                if (last_sy) begin
                                    OVERLAY_DONE <= 1'b1;
                                    state        <= S_DONE;
                                end else begin
                                    sy     <= sy + YW'(1);
                                    base_y <= base_y + 10'(SCALE);
                                    ROM_RE <= 1'b1;
                                    state  <= S_FETCH;
                                end
                            end else begin
                                sx     <= sx + XW'(1);
                                base_x <= base_x + 10'(SCALE);
                                ROM_RE <= 1'b1;
                                state  <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!RUN_OVERLAY) begin
                        OVERLAY_DONE <= 1'b0;
                        BUSY         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_overlay_blit_subsystem.sv
// Testbench for overlay_blit_subsystem, scoreboard style, with a reduced
// 16x8 sprite so every scenario runs to completion quickly.
module tb_overlay_blit_subsystem;

    localparam int SW = 16;
    localparam int SH = 8;
    localparam int NM = 4;
    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst, run, wr_ready;
    logic [1:0] msg_sel;
    logic [8:0] org_x, org_y;
    logic       rom_re;
    logic [1:0] rom_id;
    logic [3:0] rom_x;
    logic [2:0] rom_y;
    logic [7:0] rom_pixel;
    logic       we;
    logic [7:0] pix;
    logic [8:0] px, py;
    logic       busy, done;

    always #5 clk = ~clk;

    overlay_blit_subsystem #(
        .SPR_W(SW), .SPR_H(SH), .NUM_MSG(NM), .SCALE(SC),
        .SCREEN_W(320), .SCREEN_H(240), .KEY_COLOR(8'hE3)
    ) dut (
        .CLOCK_50(clk), .RESET_H(rst), .RUN_OVERLAY(run), .MSG_SEL(msg_sel),
        .ORIGIN_X(org_x), .ORIGIN_Y(org_y), .WR_READY(wr_ready),
        .ROM_RE(rom_re), .ROM_ID(rom_id), .ROM_X(rom_x), .ROM_Y(rom_y),
        .ROM_PIXEL(rom_pixel), .WE(we), .PIXEL_DOUT(pix), .PIXEL_X(px),
        .PIXEL_Y(py), .BUSY(busy), .OVERLAY_DONE(done)
    );

    typedef struct {
        int         x;
        int         y;
        logic [7:0] p;
    } wr_t;

    wr_t        q[$];
    int         vectors = 0;
    int         errors  = 0;
    int         wr_cnt  = 0;
    int         cyc     = 0;
    bit         sb_en   = 0;
    bit         rand_ready = 0;
    bit         key_row0 = 0;
    bit         stalled = 0;
    logic [1:0] exp_id = '0;
    logic [8:0] hx, hy;
    logic [7:0] hp;

    always @(posedge clk) cyc <= cyc + 1;

    // Sprite ROM: pixel = x ^ y, one cycle latency, junk when not read.
    always @(posedge clk) begin
        if (rom_re)
            rom_pixel <= (key_row0 && rom_y == 3'd0) ? 8'hE3 : 8'({4'b0, rom_x} ^ {5'b0, rom_y});
        else
            rom_pixel <= 8'h5A;
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 wr_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares accepted writes against the scoreboard queue.
    always @(negedge clk) begin
        wr_t e;
        if (sb_en) begin
            if (rom_re) begin
                vectors++;
                if (rom_id !== exp_id) begin
                    errors++;
                    $display("FAIL rom_id got %0d want %0d", rom_id, exp_id);
                end
            end
            if (stalled) begin
                vectors++;
                if (we !== 1'b1 || px !== hx || py !== hy || pix !== hp) begin
                    errors++;
                    $display("FAIL stall_hold got we=%0b (%0d,%0d)=%h want we=1 (%0d,%0d)=%h",
                             we, px, py, pix, hx, hy, hp);
                end
            end
            stalled = 0;
            if (we) begin
                if (wr_ready) begin
                    vectors++;
                    wr_cnt++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_write got (%0d,%0d)=%h want none", px, py, pix);
                    end else begin
                        e = q.pop_front();
                        if (px !== 9'(e.x) || py !== 9'(e.y) || pix !== e.p) begin
                            errors++;
                            $display("FAIL write got (%0d,%0d)=%h want (%0d,%0d)=%h",
                                     px, py, pix, e.x, e.y, e.p);
                        end
                    end
                end else begin
                    stalled = 1;
                    hx = px;
                    hy = py;
                    hp = pix;
                end
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_expected(input int ox, input int oy, input bit key);
        wr_t e;
        for (int sy = 0; sy < SH; sy++)
            for (int sx = 0; sx < SW; sx++)
                for (int dy = 0; dy < SC; dy++)
                    for (int dx = 0; dx < SC; dx++) begin
                        e.x = ox + sx * SC + dx;
                        e.y = oy + sy * SC + dy;
                        e.p = (key && sy == 0) ? 8'hE3 : 8'(sx ^ sy);
                        if (e.x < 320 && e.y < 240 && !(key && e.p == 8'hE3))
                            q.push_back(e);
                    end
    endtask

    task automatic run_blit(input int ox, input int oy, input logic [1:0] m, input bit key,
                            input bit rnd, input int exp_writes, input bit chk_lat);
        int t0;
        q.delete();
        push_expected(ox, oy, key);
        exp_id   = m;
        wr_cnt   = 0;
        stalled  = 0;
        key_row0 = key;
        @(posedge clk);
        #1;
        org_x = 9'(ox); org_y = 9'(oy); msg_sel = m; run = 1'b1; wr_ready = 1'b1;
        rand_ready = rnd;
        sb_en = 1;
        @(posedge clk);
        #1;
        t0 = cyc;
        // Scramble start inputs: the block must use the latched copies.
        org_x = ~org_x; org_y = ~org_y; msg_sel = ~m;
        if (chk_lat) begin
            while (!we && cyc - t0 < 20) @(negedge clk);
            check("first_we_latency", cyc - t0, 2);
        end
        while (!done && cyc - t0 < 8000) @(negedge clk);
        check("done_raised", done, 1);
        if (chk_lat) check("done_latency", cyc - t0, SW * SH * (2 + SC * SC));
        rand_ready = 0;
        check("write_count", wr_cnt, exp_writes);
        check("queue_drained", q.size(), 0);
        check("busy_in_done", busy, 1);
        @(posedge clk);
        #1;
        run = 1'b0; wr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_fall", done, 0);
        check("busy_idle", busy, 0);
        sb_en = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  seen_done;
        rst = 1'b1; run = 1'b0; wr_ready = 1'b1; msg_sel = '0; org_x = '0; org_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", we, 0);
        check("rst_rom_re", rom_re, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_pixel", {pix, px, py}, 0);
        check("rst_rom_addr", {rom_id, rom_x, rom_y}, 0);
        rst = 1'b0;

        // Full copy, origin (0,0), sprite 2, no back-pressure.
        run_blit(0, 0, 2'd2, 1'b0, 1'b0, SW * SH * SC * SC, 1'b1);
        // Partly off-screen: 20 columns x 10 rows survive clipping.
        run_blit(300, 230, 2'd1, 1'b0, 1'b0, 200, 1'b0);
        // Random back-pressure, same write set as the first run.
        run_blit(0, 0, 2'd2, 1'b0, 1'b1, SW * SH * SC * SC, 1'b0);

        // Abort after 100 accepted writes.
        q.delete();
        push_expected(0, 0, 1'b0);
        exp_id = 2'd1; wr_cnt = 0; stalled = 0; key_row0 = 0;
        @(posedge clk);
        #1;
        org_x = '0; org_y = '0; msg_sel = 2'd1; run = 1'b1; wr_ready = 1'b1; sb_en = 1;
        t0 = cyc;
        while (wr_cnt < 100 && cyc - t0 < 2000) @(negedge clk);
        check("abort_reached_100", wr_cnt, 100);
        @(posedge clk);
        #1 run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_we_drop", we, 0);
        check("abort_busy", busy, 0);
        sb_en = 0;
        seen_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        // Restart must begin again at (0,0).
        run_blit(0, 0, 2'd3, 1'b0, 1'b0, SW * SH * SC * SC, 1'b1);

        // Reset mid-WRITE while stalled with RUN still high.
        sb_en = 0; key_row0 = 0;
        @(posedge clk);
        #1;
        msg_sel = 2'd3; org_x = '0; org_y = '0; run = 1'b1; wr_ready = 1'b1;
        t0 = cyc;
        while (!(we && rom_x == 4'd5) && cyc - t0 < 200) @(negedge clk);
        check("reset_setup_we", we, 1);
        wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_we", we, 0);
        check("midrst_rom_re", rom_re, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pixel", {pix, px, py}, 0);
        check("midrst_rom_addr", {rom_id, rom_x, rom_y}, 0);
        rst = 1'b0; run = 1'b0; wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);

`ifdef OVERLAY_TRANSPARENCY_EN
        // Row 0 of the sprite is all key colour: rows y=0..1 never written.
        run_blit(0, 0, 2'd2, 1'b1, 1'b0, (SH - 1) * SW * SC * SC, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
